// File: rtl/collision_monitor.sv
// collision_monitor: per-frame frog/car collision check feeding the HEX message select.
// Optional feature: define GRACE_PERIOD_EN for post-respawn immunity (GRACE_TICKS).
module collision_monitor #(
    parameter int COLS        = 16,
    parameter int ROWS        = 8,
    parameter int LIVES       = 3,
    parameter int HOLD_TICKS  = 8,
`ifdef GRACE_PERIOD_EN
    parameter int GRACE_TICKS = 16,
`endif
    localparam int XW = $clog2(COLS),
    localparam int YW = $clog2(ROWS) + 1,
    localparam int LW = $clog2(LIVES + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            frame_tick,
    input  logic            start,
    input  logic [XW-1:0]   frog_x,
    input  logic [YW-1:0]   frog_y,
    output logic            row_rd_req,
    output logic [YW-2:0]   row_rd_addr,
    input  logic            row_rd_valid,
    input  logic [COLS-1:0] row_rd_data,
    output logic            hit,
    output logic            respawn,
    output logic [LW-1:0]   lives,
    output logic            game_over
);

    localparam int HW = $clog2(HOLD_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DEAD
    } state_e;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-2:0] y_q, y_d;
    logic          req_q, req_d;
    logic          hit_q, hit_d;
    logic          respawn_q, respawn_d;
    logic [LW-1:0] lives_q, lives_d;
    logic          game_over_q, game_over_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          immune;

`ifdef GRACE_PERIOD_EN
    localparam int GW = $clog2(GRACE_TICKS + 1);

    logic [GW-1:0] grace_q, grace_d;

    assign immune = (grace_q != '0);

    // Grace counter: counts frame ticks down, reloaded by every respawn pulse
    always_comb begin
        grace_d = grace_q;
        if (frame_tick && grace_q != '0) begin
            grace_d = grace_q - GW'(1);
        end
        if (respawn_d) begin
            grace_d = GW'(GRACE_TICKS);
        end
    end

    // Grace counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grace_q <= '0;
        end else begin
            grace_q <= grace_d;
        end
    end
`else
    assign immune = 1'b0;
`endif

    // Next-state and registered-output logic; start overrides everything
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        req_d       = 1'b0;
        hit_d       = hit_q;
        respawn_d   = 1'b0;
        lives_d     = lives_q;
        game_over_d = game_over_q;
        hold_d      = hold_q;
        if (start) begin
            state_d     = IDLE;
            lives_d     = LW'(LIVES);
            hit_d       = 1'b0;
            game_over_d = 1'b0;
            respawn_d   = 1'b1;
            hold_d      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        x_d = frog_x;
                        if (int'(frog_y) < ROWS && !immune) begin
                            y_d     = frog_y[YW-2:0];
                            req_d   = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (row_rd_valid) begin
                        if (row_rd_data[x_q]) begin
                            hit_d   = 1'b1;
                            lives_d = (lives_q == '0) ? '0 : lives_q - LW'(1);
                            hold_d  = '0;
                            state_d = HOLD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (frame_tick) begin
                        hold_d = hold_q + HW'(1);
                        if (hold_q == HW'(HOLD_TICKS - 1)) begin
                            if (lives_q == '0) begin
                                game_over_d = 1'b1;
                                state_d     = DEAD;
                            end else begin
                                hit_d     = 1'b0;
                                respawn_d = 1'b1;
                                state_d   = IDLE;
                            end
                        end
                    end
                end
                DEAD: begin
                    state_d = DEAD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            req_q       <= 1'b0;
            hit_q       <= 1'b0;
            respawn_q   <= 1'b0;
            lives_q     <= LW'(LIVES);
            game_over_q <= 1'b0;
            hold_q      <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            req_q       <= req_d;
            hit_q       <= hit_d;
            respawn_q   <= respawn_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            hold_q      <= hold_d;
        end
    end

    assign row_rd_req  = req_q;
    assign row_rd_addr = y_q;
    assign hit         = hit_q;
    assign respawn     = respawn_q;
    assign lives       = lives_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_collision_monitor.sv
// tb_collision_monitor: directed + randomized bench for collision_monitor
// against a game-level model (lives, hold frames, grace frames).
`timescale 1ns/1ps
module tb_collision_monitor;

    localparam int COLS  = 16;
    localparam int ROWS  = 8;
    localparam int LIVES = 3;
    localparam int HOLD  = 8;
`ifdef GRACE_PERIOD_EN
    localparam int GRACE = 16;
`else
    localparam int GRACE = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        frame_tick;
    logic        start;
    logic [3:0]  frog_x;
    logic [3:0]  frog_y;
    logic        row_rd_req;
    logic [2:0]  row_rd_addr;
    logic        row_rd_valid;
    logic [15:0] row_rd_data;
    logic        hit;
    logic        respawn;
    logic [1:0]  lives;
    logic        game_over;

    int checks   = 0;
    int failures = 0;

    int m_lives;
    bit m_hit;
    bit m_dead;
    int m_hold;
    int m_grace;

    collision_monitor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_tick   (frame_tick),
        .start        (start),
        .frog_x       (frog_x),
        .frog_y       (frog_y),
        .row_rd_req   (row_rd_req),
        .row_rd_addr  (row_rd_addr),
        .row_rd_valid (row_rd_valid),
        .row_rd_data  (row_rd_data),
        .hit          (hit),
        .respawn      (respawn),
        .lives        (lives),
        .game_over    (game_over)
    );

    always #10 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".hit"}, 32'(hit), 32'(m_hit));
        chk({tag, ".lives"}, 32'(lives), 32'(m_lives));
        chk({tag, ".game_over"}, 32'(game_over), 32'(m_dead));
    endtask

    task automatic m_new_game();
        m_lives = LIVES;
        m_hit   = 1'b0;
        m_dead  = 1'b0;
        m_hold  = 0;
        m_grace = GRACE;
    endtask

    task automatic m_reset();
        m_new_game();
        m_grace = 0;
    endtask

    // One game frame: tick, and if a read is due, play the occupancy memory.
    task automatic frame(input int x, input int y, input logic [15:0] data,
                         input int delay, input bit noise);
        bit exp_req;
        bit exp_resp;
        exp_req  = 1'b0;
        exp_resp = 1'b0;
        frog_x = 4'(x);
        frog_y = 4'(y);
        frame_tick = 1'b1;
        if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) begin
                if (m_lives == 0) begin
                    m_dead = 1'b1;
                end else begin
                    m_hit    = 1'b0;
                    exp_resp = 1'b1;
                end
            end
        end else if (!m_dead) begin
            exp_req = (y < ROWS) && (m_grace == 0);
        end
        if (m_grace > 0) m_grace--;
        if (exp_resp) m_grace = GRACE;
        cyc();
        frame_tick = 1'b0;
        chk("tick.req", 32'(row_rd_req), 32'(exp_req));
        chk("tick.respawn", 32'(respawn), 32'(exp_resp));
        chk_state("tick");
        if (exp_req) begin
            chk("tick.addr", 32'(row_rd_addr), 32'(y));
            cyc();
            chk("wait.req_drop", 32'(row_rd_req), 32'd0);
            for (int d = 1; d < delay; d++) begin
                frame_tick = noise && ($urandom_range(1) == 1);
                cyc();
                frame_tick = 1'b0;
                chk("wait.quiet", 32'({row_rd_req, hit}), 32'd0);
            end
            row_rd_valid = 1'b1;
            row_rd_data  = data;
            cyc();
            row_rd_valid = 1'b0;
            row_rd_data  = 16'($urandom);
            if (data[x]) begin
                m_hit = 1'b1;
                if (m_lives > 0) m_lives--;
                m_hold = HOLD;
            end
            chk("valid.req", 32'(row_rd_req), 32'd0);
            chk("valid.respawn", 32'(respawn), 32'd0);
            chk_state("valid");
        end
    endtask

    task automatic do_start(input bit with_tick);
        start      = 1'b1;
        frame_tick = with_tick;
        frog_y     = 4'd3;
        cyc();
        start      = 1'b0;
        frame_tick = 1'b0;
        m_new_game();
        chk("start.respawn", 32'(respawn), 32'd1);
        chk("start.req", 32'(row_rd_req), 32'd0);
        chk_state("start");
        cyc();
        chk("start.pulse_end", 32'(respawn), 32'd0);
        chk("start.no_req", 32'(row_rd_req), 32'd0);
    endtask

    task automatic clear_grace();
        for (int i = 0; i < GRACE; i++) frame(0, 9, 16'h0, 1, 1'b0);
    endtask

    initial begin
        reset_n      = 1'b0;
        frame_tick   = 1'b0;
        start        = 1'b0;
        frog_x       = '0;
        frog_y       = '0;
        row_rd_valid = 1'b0;
        row_rd_data  = '0;
        m_reset();
        cyc();
        cyc();
        chk("reset.req", 32'(row_rd_req), 32'd0);
        chk("reset.respawn", 32'(respawn), 32'd0);
        chk_state("reset");
        reset_n = 1'b1;
        cyc();

        // Hit with the reply two cycles after the request
        frame(5, 3, 16'h0020, 2, 1'b0);
        // Eight hold ticks, the last one respawns
        for (int i = 0; i < HOLD; i++) frame(i, 2, 16'hFFFF, 1, 1'b0);
        // Checks resume right away, or after the grace window
        for (int i = 0; i <= GRACE; i++) frame(5, 3, 16'h0000, 1, 1'b0);
        // Miss: neighbours occupied but not the frog's column
        frame(5, 3, 16'hFFDF, 2, 1'b0);
        frame(5, 3, 16'hFFDF, 1, 1'b0);

        // Lose every life
        for (int i = 0; i < 400 && !m_dead; i++) frame(2, 1, 16'h0004, 1, 1'b0);
        chk("dead.reached", 32'(m_dead), 32'd1);
        for (int i = 0; i < 3; i++) frame(2, 1, 16'h0004, 1, 1'b0);
        do_start(1'b0);

        // Off-road frog, then start racing a tick
        frame(0, 8, 16'hFFFF, 1, 1'b0);
        do_start(1'b1);

        // start while a read is pending; its late valid must be ignored
        clear_grace();
        frog_x = 4'd7;
        frog_y = 4'd2;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("pend.req", 32'(row_rd_req), 32'd1);
        cyc();
        do_start(1'b0);
        row_rd_valid = 1'b1;
        row_rd_data  = 16'hFFFF;
        cyc();
        row_rd_valid = 1'b0;
        chk_state("pend.stale");

        // Reset during a read
        clear_grace();
        frog_x = 4'd1;
        frog_y = 4'd4;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("rst.req_before", 32'(row_rd_req), 32'd1);
        reset_n = 1'b0;
        #1;
        m_reset();
        chk("rst.req_cleared", 32'(row_rd_req), 32'd0);
        chk_state("rst.async");
        cyc();
        reset_n = 1'b1;
        row_rd_valid = 1'b1;
        row_rd_data  = 16'hFFFF;
        cyc();
        row_rd_valid = 1'b0;
        chk_state("rst.stale");
        frame(1, 4, 16'h0000, 1, 1'b0);

        // Randomized play
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 3 || (m_dead && $urandom_range(9) == 0)) begin
                do_start(1'($urandom_range(1)));
            end else begin
                frame(int'($urandom_range(15)), int'($urandom_range(9)),
                      16'($urandom & $urandom), int'($urandom_range(4, 1)), 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
